// File: rtl/tile_sprite_fetcher.sv
// tile_sprite_fetcher: maps raster pixels onto a 15x13 tile field and fetches each pixel's sprite texel.
// Latency: fixed 3 cycles from pix_valid/draw_x/draw_y to pix_*; one pixel per cycle.
// Backpressure: none; the pipeline never stalls and pix_valid=0 cycles travel through as bubbles.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pix_valid, draw_x, draw_y   raster pixel in (x steps by one per valid cycle within a line)
//   grid_addr -> grid_state     occupancy-grid lookup, data sampled one cycle after the address
//   rom_state, rom_addr         sprite select and texel address to the sprite ROM
//   rom_data                    palette index, sampled one cycle after rom_state/rom_addr
//   pix_out_valid, pix_in_field, pix_index, pix_x, pix_y   resolved pixel out
module tile_sprite_fetcher #(
   parameter int X0   = 95,   // field left edge, px
   parameter int Y0   = 45,   // field top edge, px
   parameter int TILE = 30,   // tile edge, px
   parameter int COLS = 15,
   parameter int ROWS = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_valid,
   input  logic [9:0] draw_x,
   input  logic [9:0] draw_y,
   output logic [7:0] grid_addr,
   input  logic [3:0] grid_state,
   output logic [3:0] rom_state,
   output logic [9:0] rom_addr,
   input  logic [3:0] rom_data,
   output logic       pix_out_valid,
   output logic       pix_in_field,
   output logic [3:0] pix_index,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y
);

   localparam logic [9:0] X_FIRST   = 10'(X0);
   localparam logic [9:0] X_LAST    = 10'(X0 + TILE * COLS - 1);
   localparam logic [9:0] Y_FIRST   = 10'(Y0);
   localparam logic [9:0] Y_LAST    = 10'(Y0 + TILE * ROWS - 1);
   localparam logic [4:0] OFF_LAST  = 5'(TILE - 1);
   localparam logic [3:0] COL_LAST  = 4'(COLS - 1);
   localparam logic [3:0] ROW_LAST  = 4'(ROWS - 1);
   localparam logic [7:0] ROW_STEP  = 8'(COLS);
   localparam logic [9:0] TILE_W    = 10'(TILE);
   localparam logic [3:0] OCC_MAX   = 4'd12;  // highest sprite code the ROM holds
   localparam logic [3:0] OCC_NONE  = 4'd0;   // grass

   // ------------------------------------------------------------------
   // Field decode
   // ------------------------------------------------------------------
   logic in_field;
   logic row_span;     // draw_y is a field row other than the first
   logic line_start;

   assign in_field   = pix_valid &&
                       (draw_x >= X_FIRST) && (draw_x <= X_LAST) &&
                       (draw_y >= Y_FIRST) && (draw_y <= Y_LAST);
   assign row_span   = (draw_y > Y_FIRST) && (draw_y <= Y_LAST);
   assign line_start = pix_valid && (draw_x == X_FIRST);

   // ------------------------------------------------------------------
   // Tile position counters
   // The registers hold the position of the most recent field pixel, so
   // the *_n values are the position of the pixel being presented now.
   // Stage A addresses from *_n, which lets the first pixel of a line use
   // xoff=0/col=0 without waiting a cycle for the line-entry reset.
   // ------------------------------------------------------------------
   logic [4:0] xoff, xoff_n;
   logic [3:0] col,  col_n;
   logic [4:0] yoff, yoff_n;
   logic [3:0] row,  row_n;
   logic [7:0] row_base, row_base_n;   // row * COLS, kept as a running sum

   always_comb begin
      xoff_n     = xoff;
      col_n      = col;
      yoff_n     = yoff;
      row_n      = row;
      row_base_n = row_base;
      if (line_start) begin
         xoff_n = 5'd0;
         col_n  = 4'd0;
         if (draw_y == Y_FIRST) begin
            yoff_n     = 5'd0;
            row_n      = 4'd0;
            row_base_n = 8'd0;
         end else if (row_span) begin
            if (yoff == OFF_LAST) begin
               yoff_n = 5'd0;
               if (row != ROW_LAST) begin
                  row_n      = row + 4'd1;
                  row_base_n = row_base + ROW_STEP;
               end
            end else begin
               yoff_n = yoff + 5'd1;
            end
         end
      end else if (in_field) begin
         if (xoff == OFF_LAST) begin
            xoff_n = 5'd0;
            // Field edge: col stays on the last tile rather than running off the grid.
            if (col != COL_LAST) begin
               col_n = col + 4'd1;
            end
         end else begin
            xoff_n = xoff + 5'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage A: grid lookup address plus side-band
   // ------------------------------------------------------------------
   logic [4:0] a_xoff;
   logic [4:0] a_yoff;
   logic       a_in_field;
   logic       a_vld;
   logic [9:0] a_x;
   logic [9:0] a_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xoff       <= 5'd0;
         col        <= 4'd0;
         yoff       <= 5'd0;
         row        <= 4'd0;
         row_base   <= 8'd0;
         grid_addr  <= 8'd0;
         a_xoff     <= 5'd0;
         a_yoff     <= 5'd0;
         a_in_field <= 1'b0;
         a_vld      <= 1'b0;
         a_x        <= 10'd0;
         a_y        <= 10'd0;
      end else begin
         xoff     <= xoff_n;
         col      <= col_n;
         yoff     <= yoff_n;
         row      <= row_n;
         row_base <= row_base_n;
         // Off-field pixels leave the grid address where it was.
         if (in_field) begin
            grid_addr <= row_base_n + {4'd0, col_n};
         end
         a_xoff     <= xoff_n;
         a_yoff     <= yoff_n;
         a_in_field <= in_field;
         a_vld      <= pix_valid;
         a_x        <= draw_x;
         a_y        <= draw_y;
      end
   end

   // ------------------------------------------------------------------
   // Stage B: sprite select and texel address
   // ------------------------------------------------------------------
   logic [9:0] tex_addr;
   logic       b_in_field;
   logic       b_vld;
   logic [9:0] b_x;
   logic [9:0] b_y;

   // Constant multiply by the tile edge; 29*30+29 = 899 fits in 10 bits.
   assign tex_addr = ({5'd0, a_yoff} * TILE_W) + {5'd0, a_xoff};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_state  <= OCC_NONE;
         rom_addr   <= 10'd0;
         b_in_field <= 1'b0;
         b_vld      <= 1'b0;
         b_x        <= 10'd0;
         b_y        <= 10'd0;
      end else begin
         // Codes above the sprite range have no ROM image; draw them as grass.
         if (a_in_field && (grid_state <= OCC_MAX)) begin
            rom_state <= grid_state;
         end else begin
            rom_state <= OCC_NONE;
         end
         if (a_in_field) begin
            rom_addr <= tex_addr;
         end
         b_in_field <= a_in_field;
         b_vld      <= a_vld;
         b_x        <= a_x;
         b_y        <= a_y;
      end
   end

   // ------------------------------------------------------------------
   // Stage C: palette index out
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_index     <= 4'h0;
         pix_in_field  <= 1'b0;
         pix_out_valid <= 1'b0;
         pix_x         <= 10'd0;
         pix_y         <= 10'd0;
      end else begin
         pix_index     <= b_in_field ? rom_data : 4'h0;
         pix_in_field  <= b_in_field;
         pix_out_valid <= b_vld;
         pix_x         <= b_x;
         pix_y         <= b_y;
      end
   end

endmodule

// File: tb/tb_tile_sprite_fetcher.sv
// tb_tile_sprite_fetcher: randomized raster stimulus against a coordinate-arithmetic reference model.
// Latency: expects every valid pixel on pix_* exactly 3 cycles after it is presented.
// Backpressure: none; open-loop stimulus, scoreboard queue drained by a negedge monitor.
module tb_tile_sprite_fetcher;

   localparam int X0     = 95;
   localparam int Y0     = 45;
   localparam int TILE   = 30;
   localparam int COLS   = 15;
   localparam int ROWS   = 13;
   localparam int X_LAST = X0 + TILE * COLS - 1;
   localparam int Y_LAST = Y0 + TILE * ROWS - 1;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       pix_valid = 1'b0;
   logic [9:0] draw_x    = 10'd0;
   logic [9:0] draw_y    = 10'd0;
   logic [7:0] grid_addr;
   logic [3:0] grid_state;
   logic [3:0] rom_state;
   logic [9:0] rom_addr;
   logic [3:0] rom_data;
   logic       pix_out_valid;
   logic       pix_in_field;
   logic [3:0] pix_index;
   logic [9:0] pix_x;
   logic [9:0] pix_y;

   tile_sprite_fetcher dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pix_valid     (pix_valid),
      .draw_x        (draw_x),
      .draw_y        (draw_y),
      .grid_addr     (grid_addr),
      .grid_state    (grid_state),
      .rom_state     (rom_state),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .pix_out_valid (pix_out_valid),
      .pix_in_field  (pix_in_field),
      .pix_index     (pix_index),
      .pix_x         (pix_x),
      .pix_y         (pix_y)
   );

   always #5 clk = ~clk;

   // Occupancy grid and sprite ROM images; read data returns in the cycle the address is shown.
   logic [3:0] grid_mem [COLS*ROWS];
   logic [3:0] rom_mem  [13][TILE*TILE];

   always_comb begin
      grid_state = 4'h0;
      if (int'(grid_addr) < COLS * ROWS) grid_state = grid_mem[grid_addr];
   end

   always_comb begin
      rom_data = 4'h0;
      if (rom_state <= 4'd12 && int'(rom_addr) < TILE * TILE) rom_data = rom_mem[rom_state][rom_addr];
   end

   typedef struct {
      int t;    // cycle the pixel was presented
      int x;
      int y;
      int inf;
      int ga;
      int rs;
      int ra;
      int idx;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   passes  = 0;
   int   cyc     = 0;
   int   last_ga = 0;
   int   last_ra = 0;
   int   hist_ga [16];
   int   hist_rs [16];
   int   hist_ra [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: tile position straight from field-relative coordinates.
   task automatic push_expect(input int x, input int y, input int t);
      exp_t e;
      int   gs;
      e.t   = t;
      e.x   = x;
      e.y   = y;
      e.inf = (x >= X0 && x <= X_LAST && y >= Y0 && y <= Y_LAST) ? 1 : 0;
      if (e.inf != 0) begin
         e.ga    = ((y - Y0) / TILE) * COLS + (x - X0) / TILE;
         e.ra    = ((y - Y0) % TILE) * TILE + (x - X0) % TILE;
         gs      = int'(grid_mem[e.ga]);
         e.rs    = (gs <= 12) ? gs : 0;
         e.idx   = int'(rom_mem[e.rs][e.ra]);
         last_ga = e.ga;
         last_ra = e.ra;
      end else begin
         e.ga  = last_ga;
         e.ra  = last_ra;
         e.rs  = 0;
         e.idx = 0;
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_pix(input logic v, input int x, input int y);
      @(negedge clk);
      pix_valid = v;
      draw_x    = 10'(x);
      draw_y    = 10'(y);
      if (v) push_expect(x, y, cyc + 1);
   endtask

   // Invalid cycle with junk coordinates, often sitting on the line-entry column.
   task automatic drive_junk();
      int jx;
      int jy;
      jx = ($urandom_range(0, 3) == 0) ? X0 : int'($urandom_range(0, 1023));
      jy = ($urandom_range(0, 3) == 0) ? Y0 : int'($urandom_range(0, 1023));
      drive_pix(1'b0, jx, jy);
   endtask

   // mode 0: random bubbles; mode 1: strict valid/invalid alternation.
   task automatic scan_line(input int y, input int xs, input int xe, input int mode);
      for (int x = xs; x <= xe; x++) begin
         if (mode == 1) begin
            drive_pix(1'b1, x, y);
            drive_junk();
         end else begin
            if ($urandom_range(0, 7) == 0) drive_junk();
            drive_pix(1'b1, x, y);
         end
      end
      repeat ($urandom_range(1, 3)) drive_junk();
   endtask

   // Called at a negedge: reset lands mid-cycle and outputs must clear before the next posedge.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grid_addr",     int'(grid_addr),     0);
      chk("rst_rom_state",     int'(rom_state),     0);
      chk("rst_rom_addr",      int'(rom_addr),      0);
      chk("rst_pix_index",     int'(pix_index),     0);
      chk("rst_pix_x",         int'(pix_x),         0);
      chk("rst_pix_y",         int'(pix_y),         0);
      chk("rst_pix_out_valid", int'(pix_out_valid), 0);
      chk("rst_pix_in_field",  int'(pix_in_field),  0);
      exp_q.delete();
      last_ga   = 0;
      last_ra   = 0;
      pix_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: record the address stages every cycle, pop and compare on each output pixel.
   always @(negedge clk) begin : mon
      int   cur;
      exp_t e;
      if (rst_n) begin
         cur = cyc + 1;
         hist_ga[cur % 16] = int'(grid_addr);
         hist_rs[cur % 16] = int'(rom_state);
         hist_ra[cur % 16] = int'(rom_addr);
         if (pix_out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_out: pix_out_valid=1 at cycle %0d (x=%0d y=%0d), expected no pixel",
                        cur, pix_x, pix_y);
            end else begin
               e = exp_q.pop_front();
               chk("latency",      cur,                      e.t + 3);
               chk("pix_x",        int'(pix_x),              e.x);
               chk("pix_y",        int'(pix_y),              e.y);
               chk("pix_in_field", int'(pix_in_field),       e.inf);
               chk("pix_index",    int'(pix_index),          e.idx);
               chk("grid_addr",    hist_ga[(e.t + 1) % 16],  e.ga);
               chk("rom_state",    hist_rs[(e.t + 2) % 16],  e.rs);
               chk("rom_addr",     hist_ra[(e.t + 2) % 16],  e.ra);
            end
         end
      end
   end

   initial begin
      int  xe;
      int  mode;
      bit  full;

      for (int i = 0; i < COLS * ROWS; i++) grid_mem[i] = 4'($urandom_range(0, 15));
      for (int s = 0; s < 13; s++)
         for (int a = 0; a < TILE * TILE; a++) rom_mem[s][a] = 4'($urandom_range(0, 15));
      grid_mem[0]        = 4'd5;    // cell (0,0) holds sprite 5
      rom_mem[5][0]      = 4'hA;
      grid_mem[2*COLS+3] = 4'd14;   // cell (3,2) holds an out-of-range code

      pulse_reset();

      // Stray pixels before any frame.
      drive_pix(1'b1, 10, 10);
      drive_junk();

      // Frame 1: every line entered at X0; some lines full width, the rest short.
      for (int y = Y0 - 2; y <= Y_LAST + 2; y++) begin
         full = (y == 45 || y == 74 || y == 75 || y == 76 || y == 110 || y == 300 || y == Y_LAST) ||
                ($urandom_range(0, 11) == 0);
         mode = (y == 76) ? 1 : 0;
         xe   = full ? X_LAST + int'($urandom_range(0, 3)) : X0 + int'($urandom_range(0, 6));
         scan_line(y, X0 - int'($urandom_range(0, 3)), xe, mode);
         if (y == 300) begin
            drive_pix(1'b1, 600, 300);
            drive_junk();
         end
      end

      // Frame 2: reset lands in the middle of the second field line.
      scan_line(Y0 - 1, X0 - 2, X0 + 3, 0);
      scan_line(Y0, X0 - 1, X_LAST + 1, 0);
      for (int x = X0 - 1; x <= 300; x++) drive_pix(1'b1, x, Y0 + 1);
      pulse_reset();
      repeat (2) drive_junk();

      // Frame 3 after reset: restarts cleanly from (X0,Y0).
      for (int y = Y0 - 1; y <= Y0 + 31; y++) begin
         full = (y == 45 || y == 74 || y == 75) || ($urandom_range(0, 7) == 0);
         xe   = full ? X_LAST + 1 : X0 + int'($urandom_range(0, 6));
         scan_line(y, X0 - 1, xe, 0);
      end

      repeat (8) drive_pix(1'b0, 0, 0);
      chk("drain_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
